// File: rtl/demux_1to4_reg_if.sv
// Handshake/bus bundle for demux_1to4_reg: one producer port, four consumer lanes.
interface demux_1to4_reg_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0]   datain;
  logic               in_valid;
  logic [1:0]         select;
  logic               in_ready;
  logic [4*WIDTH-1:0] outd;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;

  // Driven by the producer/consumers (testbench side)
  modport master (
    output datain, in_valid, select, out_ready,
    input  in_ready, outd, out_valid
  );

  // Driven by the demultiplexer
  modport slave (
    input  datain, in_valid, select, out_ready,
    output in_ready, outd, out_valid
  );
endinterface

// File: rtl/demux_1to4_reg.sv
// Registered 1-to-4 demultiplexer with per-lane one-entry holding registers.
// A word is accepted when its target lane is empty or draining this cycle; a
// load and a drain on the same lane in one cycle keep the lane full with the new word.
// Optional feature macro: DEMUX_XCHECK_EN (rejects X/Z select, pulses sel_err).
module demux_1to4_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  demux_1to4_reg_if.slave  bus,
  output logic             sel_err,
  output logic [CNT_W-1:0] xfer_cnt
);

  logic [WIDTH-1:0] lane_q [4];
  logic [3:0]       valid_q;
  logic [3:0]       load;
  logic             sel_bad;
  logic             lane_free;
  logic             accept;

`ifdef DEMUX_XCHECK_EN
  assign sel_bad = bus.in_valid & $isunknown(bus.select);
`else
  assign sel_bad = 1'b0;
`endif

  // Acceptance: target lane free (empty or draining now), never on a bad select
  always_comb begin
    lane_free = ~valid_q[bus.select] | bus.out_ready[bus.select];
    accept    = bus.in_valid & lane_free & ~sel_bad;
    load      = '0;
    if (accept) load[bus.select] = 1'b1;
  end

  assign bus.in_ready  = lane_free & ~sel_bad;
  assign bus.out_valid = valid_q;

  for (genvar g = 0; g < 4; g++) begin : g_pack
    assign bus.outd[g*WIDTH +: WIDTH] = lane_q[g];
  end

  // Lane registers and transfer counter; load takes priority over drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      xfer_cnt <= '0;
      for (int unsigned k = 0; k < 4; k++) lane_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (load[k]) begin
          lane_q[k]  <= bus.datain;
          valid_q[k] <= 1'b1;
        end else if (bus.out_ready[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
      if (accept) xfer_cnt <= xfer_cnt + CNT_W'(1);
    end
  end

`ifdef DEMUX_XCHECK_EN
  // Registered one-cycle flag for each rejected X/Z select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
    end else begin
      sel_err <= sel_bad;
      if (sel_bad) $error("demux_1to4_reg: X/Z select with in_valid=1, word rejected");
    end
  end
`else
  assign sel_err = 1'b0;
`endif

endmodule
